// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and size defaults for the convolution stream scheduler
package conv_pkg;
    localparam int DIM_W_DEF = 16;
    localparam int KMAX_DEF  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - enable-driven counter that wraps to zero after reaching a terminal value
module wrap_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         wrap
);
    logic [W-1:0] count_q, count_d;

    assign count = count_q;
    assign wrap  = en && (count_q == term);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/conv_stream_scheduler.sv
// rtl/conv_stream_scheduler.sv - raster pixel scheduler emitting line-buffer writes and KxK window-valid flags
module conv_stream_scheduler
    import conv_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF,
    parameter int KMAX  = KMAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [2:0]       cfg_kernel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_stall,
    output logic             lb_wr_en,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             win_valid,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);
    localparam logic [3:0] KMAX_L = 4'(KMAX);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
    logic [2:0]       k_q, k_d;
    logic [DIM_W-1:0] row_cnt_q, row_cnt_d;
    logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic             lb_wr_en_q, lb_wr_en_d;
    logic             win_valid_q, win_valid_d;
    logic             cfg_err_q, cfg_err_d;

    logic             run, accept, cfg_ok, col_clr, col_wrap;
    logic [DIM_W-1:0] col_cnt, col_term, h_m1, k_m1, cfg_k_ext;

    assign run       = (state_q == RUN);
    assign in_ready  = run && !out_stall;
    assign accept    = in_valid && in_ready;
    assign busy      = run;
    assign done      = (state_q == DONE);
    assign lb_wr_en  = lb_wr_en_q;
    assign win_valid = win_valid_q;
    assign col       = col_q;
    assign row       = row_q;
    assign cfg_err   = cfg_err_q;

    assign cfg_k_ext = {{(DIM_W-3){1'b0}}, cfg_kernel};
    assign cfg_ok    = (cfg_kernel != 3'd0) && ({1'b0, cfg_kernel} <= KMAX_L) &&
                       (cfg_width >= cfg_k_ext) && (cfg_height >= cfg_k_ext);

    // Minus-one terms are only formed in RUN, where a passed check guarantees W, H, K >= 1.
    assign col_term  = run ? w_q - 1'b1 : '0;
    assign h_m1      = run ? h_q - 1'b1 : '0;
    assign k_m1      = run ? {{(DIM_W-3){1'b0}}, k_q} - 1'b1 : '0;

    wrap_counter #(.W(DIM_W)) u_col_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (col_clr),
        .en    (accept),
        .term  (col_term),
        .count (col_cnt),
        .wrap  (col_wrap)
    );

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        k_d         = k_q;
        row_cnt_d   = row_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        lb_wr_en_d  = 1'b0;
        win_valid_d = 1'b0;
        cfg_err_d   = cfg_err_q;
        col_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d = cfg_width;
                    h_d = cfg_height;
                    k_d = cfg_kernel;
                    if (cfg_ok) begin
                        cfg_err_d = 1'b0;
                        row_cnt_d = '0;
                        col_clr   = 1'b1;
                        state_d   = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    lb_wr_en_d  = 1'b1;
                    col_d       = col_cnt;
                    row_d       = row_cnt_q;
                    win_valid_d = (row_cnt_q >= k_m1) && (col_cnt >= k_m1);
                    if (col_wrap) begin
                        row_cnt_d = row_cnt_q + 1'b1;
                        if (row_cnt_q == h_m1) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            k_q         <= '0;
            row_cnt_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            lb_wr_en_q  <= 1'b0;
            win_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            k_q         <= k_d;
            row_cnt_q   <= row_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lb_wr_en_q  <= lb_wr_en_d;
            win_valid_q <= win_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end
endmodule

// File: tb/tb_conv_stream_scheduler.sv
// tb/tb_conv_stream_scheduler.sv - directed scoreboard bench for conv_stream_scheduler
module tb_conv_stream_scheduler;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_width = '0;
    logic [DW-1:0] cfg_height = '0;
    logic [2:0]    cfg_kernel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_stall = 1'b0;
    logic          lb_wr_en;
    logic [DW-1:0] col, row;
    logic          win_valid, busy, done, cfg_err;

    conv_stream_scheduler #(.DIM_W(DW), .KMAX(7)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_kernel(cfg_kernel),
        .in_valid(in_valid), .in_ready(in_ready), .out_stall(out_stall),
        .lb_wr_en(lb_wr_en), .col(col), .row(row), .win_valid(win_valid),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        bit w;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_state = 0;
    bit   m_err = 0;
    int   m_w = 0, m_h = 0, m_k = 0, m_row = 0, m_col = 0;
    int   n_strobe = 0, n_win = 0, n_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int w, input int h, input int k);
        cfg_width  = DW'(w);
        cfg_height = DW'(h);
        cfg_kernel = 3'(k);
    endtask

    task automatic clr_counts();
        n_strobe = 0;
        n_win    = 0;
        n_done   = 0;
    endtask

    task automatic cyc(input logic v, input logic s, input logic st);
        bit   exp_ready, acc, bad;
        exp_t e;
        in_valid  = v;
        out_stall = s;
        start     = st;
        #1;
        exp_ready = (m_state == 1) && !s;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        case (m_state)
            0: if (st) begin
                bad = (cfg_kernel == 0) || (cfg_kernel > 7) ||
                      (cfg_width < DW'(cfg_kernel)) || (cfg_height < DW'(cfg_kernel));
                if (bad) begin
                    m_err = 1;
                end else begin
                    m_err = 0; m_state = 1;
                    m_w = int'(cfg_width); m_h = int'(cfg_height); m_k = int'(cfg_kernel);
                    m_row = 0; m_col = 0;
                end
            end
            1: if (acc) begin
                e.r = m_row; e.c = m_col;
                e.w = (m_row >= m_k - 1) && (m_col >= m_k - 1);
                exp_q.push_back(e);
                if (m_col == m_w - 1) begin
                    m_col = 0;
                    if (m_row == m_h - 1) m_state = 2;
                    m_row++;
                end else begin
                    m_col++;
                end
            end
            default: m_state = 0;
        endcase
        chk("busy", 32'(busy), 32'(m_state == 1));
        chk("done", 32'(done), 32'(m_state == 2));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("lb_wr_en", 32'(lb_wr_en), 32'(exp_q.size() != 0));
        if (lb_wr_en && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("row", 32'(row), 32'(e.r));
            chk("col", 32'(col), 32'(e.c));
            chk("win_valid", 32'(win_valid), 32'(e.w));
        end else begin
            chk("win_idle", 32'(win_valid), 32'd0);
        end
        if (lb_wr_en) n_strobe++;
        if (win_valid) n_win++;
        if (done) n_done++;
    endtask

    task automatic finish_frame(input int budget);
        int n = 0;
        while (m_state != 0 && n < budget) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("frame_timeout", 32'(m_state), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_lb_wr_en", 32'(lb_wr_en), 32'd0);
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
    endtask

    task automatic model_reset();
        m_state = 0; m_err = 0; m_row = 0; m_col = 0;
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // nominal 4x4, K=3
        set_cfg(4, 4, 3); clr_counts();
        cyc(1'b0, 1'b0, 1'b1);
        finish_frame(60);
        chk("nom_strobes", 32'(n_strobe), 32'd16);
        chk("nom_wins", 32'(n_win), 32'd4);
        chk("nom_dones", 32'(n_done), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);

        // backpressure mid-row
        clr_counts();
        cyc(1'b0, 1'b0, 1'b1);
        repeat (6) cyc(1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        finish_frame(60);
        chk("bp_strobes", 32'(n_strobe), 32'd16);
        chk("bp_dones", 32'(n_done), 32'd1);

        // bad configuration, then K=1 recovery frame
        set_cfg(2, 4, 3); clr_counts();
        cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("bad_dones", 32'(n_done), 32'd0);
        set_cfg(3, 2, 1);
        cyc(1'b0, 1'b0, 1'b1);
        finish_frame(40);
        chk("k1_strobes", 32'(n_strobe), 32'd6);
        chk("k1_wins", 32'(n_win), 32'd6);
        chk("k1_dones", 32'(n_done), 32'd1);

        // K=0 also rejected
        set_cfg(4, 4, 0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // asynchronous reset after 7 accepts
        set_cfg(4, 4, 3); clr_counts();
        cyc(1'b0, 1'b0, 1'b1);
        repeat (7) cyc(1'b1, 1'b0, 1'b0);
        chk("pre_rst_strobes", 32'(n_strobe), 32'd7);
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        clr_counts();
        cyc(1'b0, 1'b0, 1'b1);
        finish_frame(60);
        chk("post_rst_strobes", 32'(n_strobe), 32'd16);

        // start pulses during RUN are ignored
        set_cfg(5, 3, 2); clr_counts();
        cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        finish_frame(60);
        chk("rs_strobes", 32'(n_strobe), 32'd15);
        chk("rs_wins", 32'(n_win), 32'd8);
        chk("rs_dones", 32'(n_done), 32'd1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        chk("rs_after_strobes", 32'(n_strobe), 32'd15);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_stream_scheduler.md
CONV_STREAM_SCHEDULER -- requirements
Module: conv_stream_scheduler

Interface
REQ-001 SHALL have parameter DIM_W, default 16: width of image dimension configuration and position counters.
REQ-002 SHALL have parameter KMAX, default 7: largest supported kernel size K.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin a frame; sampled only in IDLE.
REQ-006 SHALL have port cfg_width, input, DIM_W: image columns W.
REQ-007 SHALL have port cfg_height, input, DIM_W: image rows H.
REQ-008 SHALL have port cfg_kernel, input, 3: kernel size K.
REQ-009 SHALL have port in_valid, input, 1: upstream pixel present.
REQ-010 SHALL have port in_ready, output, 1: scheduler accepts a pixel this cycle.
REQ-011 SHALL have port out_stall, input, 1: downstream backpressure.
REQ-012 SHALL have port lb_wr_en, output, 1: line-buffer write strobe.
REQ-013 SHALL have ports col and row, output, DIM_W each: position of the pixel written.
REQ-014 SHALL have port win_valid, output, 1: a full KxK window ends at (row,col).
REQ-015 SHALL have port busy, output, 1: high in RUN.
REQ-016 SHALL have port done, output, 1: one-cycle end-of-frame pulse.
REQ-017 SHALL have port cfg_err, output, 1: sticky configuration error flag.

Function
REQ-018 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-019 In IDLE, on start, SHALL latch W, H and K, then check the configuration.
REQ-020 Configuration check: SHALL fail if K==0, K>KMAX, W<K or H<K.
REQ-021 On check failure SHALL stay in IDLE and set cfg_err; SHALL NOT pulse done.
REQ-022 On check success SHALL clear cfg_err, zero both counters and enter RUN next cycle.
REQ-023 SHALL drive in_ready = (state==RUN) && !out_stall, combinationally.
REQ-024 Accept SHALL mean in_valid && in_ready in the same cycle.
REQ-025 Each accept SHALL register lb_wr_en=1 with col/row of that pixel, visible the following cycle (latency 1).
REQ-026 SHALL hold lb_wr_en and win_valid low in all other cycles.
REQ-027 SHALL assert win_valid with the same timing as lb_wr_en when row>=K-1 and col>=K-1.
REQ-028 Column counter SHALL increment on accept and wrap from W-1 to 0; on wrap, row SHALL increment.
REQ-029 Accept at (H-1,W-1) SHALL move the FSM to DONE.
REQ-030 In DONE, done SHALL be high for exactly one cycle, coinciding with the last lb_wr_en; the FSM SHALL then return to IDLE.
REQ-031 start while in RUN or DONE SHALL be ignored.
REQ-032 Comparisons SHALL use latched values, never live cfg inputs.
REQ-033 No underflow SHALL arise: W-1 and K-1 are formed only after the check passes.

Reset
REQ-034 rst SHALL force IDLE asynchronously, at any time including mid-frame.
REQ-035 rst SHALL force in_ready, lb_wr_en, win_valid, busy, done and cfg_err to 0, and col, row and the latched configuration to 0.
REQ-036 A frame interrupted by rst SHALL be abandoned; a new start SHALL be required.

Structure
REQ-037 Shared package conv_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the DIM_W and KMAX defaults.
REQ-038 Sub-module wrap_counter SHALL be used for the column counter: enable, terminal value and wrap output.

Verification
REQ-039 Nominal frame: W=4, H=4, K=3, in_valid held high -> 16 lb_wr_en; win_valid at (2,2), (2,3), (3,2), (3,3) only; done coincident with the (3,3) strobe.
REQ-040 Backpressure: out_stall high for 5 cycles mid-row -> in_ready low during the stall, no strobes, no lost or duplicated positions.
REQ-041 Bad configuration: W=2, K=3, start -> cfg_err=1, busy stays 0, no done; a following valid start clears cfg_err.
REQ-042 K=1, W=3, H=2 -> 6 strobes, all with win_valid=1.
REQ-043 Reset mid-run: rst after 7 accepts -> all outputs 0 immediately; next start restarts at (0,0).
REQ-044 start pulsed during RUN -> ignored; frame completes normally with exactly one done.
